// File: rtl/mips32_hazard_scoreboard.sv
// Register scoreboard for the pipe_mips32 issue stage: per-register write-back countdown
// with issue stall, drain status and a stall-cycle counter. Optional macro: MIPS32_FORWARDING_EN.

module mips32_sb_entry #(
    parameter int CW       = 3,
    parameter int ALU_LAT  = 3,
    parameter int LOAD_LAT = 4
) (
    input  logic clk1,
    input  logic rst,
    input  logic wen,
    input  logic is_load,
    output logic busy,
    output logic pend
);
    logic [CW-1:0] cnt, cnt_dec, cnt_nxt, lat_m1;
    logic          ld, ld_nxt;

    // The countdown is folded into the issue edge, so the cycle after issue reads L-1
    // and a consumer fires exactly L cycles after its producer.
    assign cnt_dec = (cnt != '0) ? cnt - 1'b1 : '0;
    assign lat_m1  = is_load ? CW'(LOAD_LAT - 1) : CW'(ALU_LAT - 1);

    always_comb begin
        cnt_nxt = cnt_dec;
        ld_nxt  = ld & (cnt_dec != '0);
        if (wen) begin
            // A later write never shortens an older, longer pending window.
            cnt_nxt = (cnt_dec > lat_m1) ? cnt_dec : lat_m1;
            ld_nxt  = is_load | (ld & (cnt_dec > lat_m1));
        end
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            cnt <= '0;
            ld  <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            ld  <= ld_nxt;
        end
    end

`ifdef MIPS32_FORWARDING_EN
    // With EX/MEM bypass only the load-use slot right after LW is unreadable.
    assign busy = ld & (cnt == CW'(LOAD_LAT - 1));
`else
    assign busy = (cnt != '0);
`endif
    assign pend = (cnt_nxt != '0);
endmodule

module mips32_hazard_scoreboard #(
    parameter int NREG     = 32,
    parameter int AW       = 5,
    parameter int ALU_LAT  = 3,
    parameter int LOAD_LAT = 4,
    parameter int CW       = 3,
    parameter int SCW      = 16
) (
    input  logic           clk1,
    input  logic           rst,
    input  logic           issue_valid,
    input  logic           uses_rs,
    input  logic [AW-1:0]  rs,
    input  logic           uses_rt,
    input  logic [AW-1:0]  rt,
    input  logic           writes_rd,
    input  logic [AW-1:0]  rd,
    input  logic           is_load,
    input  logic           flush,
    output logic           stall,
    output logic           idle,
    output logic [SCW-1:0] stall_cycles
);
    localparam int NIDX = 2 ** AW;

    // Sized to the full index space so R0 and out-of-range indices read as not busy.
    logic [NIDX-1:0] busy_vec, pend_vec;
    logic            fire;

    for (genvar r = 0; r < NIDX; r++) begin : g_reg
        if (r > 0 && r < NREG) begin : g_trk
            mips32_sb_entry #(.CW(CW), .ALU_LAT(ALU_LAT), .LOAD_LAT(LOAD_LAT)) u_ent (
                .clk1    (clk1),
                .rst     (rst),
                .wen     (fire & writes_rd & (rd == AW'(r))),
                .is_load (is_load),
                .busy    (busy_vec[r]),
                .pend    (pend_vec[r])
            );
        end else begin : g_none
            assign busy_vec[r] = 1'b0;
            assign pend_vec[r] = 1'b0;
        end
    end

    assign stall = issue_valid & ~flush &
                   ((uses_rs & busy_vec[rs]) | (uses_rt & busy_vec[rt]));
    assign fire  = issue_valid & ~flush & ~stall;

    always_ff @(posedge clk1) begin
        if (rst) begin
            idle         <= 1'b1;
            stall_cycles <= '0;
        end else begin
            idle <= ~|pend_vec;
            if (stall && stall_cycles != '1)
                stall_cycles <= stall_cycles + 1'b1;
        end
    end
endmodule
